// File: rtl/fram_bank_arbiter.sv
// Feature-SRAM port-B router: RD_PORTS read ports plus one buffered writeback port
// sharing BANK_NUM word-interleaved BRAM banks, with per-bank fixed-priority arbitration.
module fram_bank_arbiter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int BANK_NUM      = 4,
  parameter int RD_PORTS      = 2,
  parameter int WB_FIFO_DEPTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [RD_PORTS-1:0]                                 rp_valid,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]                      rp_addr,
  output logic [RD_PORTS-1:0]                                 rp_ready,
  output logic [RD_PORTS-1:0]                                 rp_rvalid,
  output logic [RD_PORTS*DATA_WIDTH-1:0]                      rp_rdata,
  input  logic                                                wp_valid,
  input  logic [ADDR_WIDTH-1:0]                               wp_addr,
  input  logic [DATA_WIDTH-1:0]                               wp_wdata,
  output logic                                                wp_ready,
  output logic [BANK_NUM-1:0]                                 bram_en,
  output logic [BANK_NUM-1:0]                                 bram_we,
  output logic [BANK_NUM*(ADDR_WIDTH-$clog2(BANK_NUM))-1:0]   bram_addr,
  output logic [BANK_NUM*DATA_WIDTH-1:0]                      bram_wdata,
  input  logic [BANK_NUM*DATA_WIDTH-1:0]                      bram_rdata,
  output logic [$clog2(WB_FIFO_DEPTH):0]                      wb_level,
  output logic                                                wb_idle,
  output logic [CNT_WIDTH-1:0]                                conflict_cnt
);

  localparam int BANK_BITS = $clog2(BANK_NUM);
  localparam int BANK_AW   = ADDR_WIDTH - BANK_BITS;
  localparam int PTR_W     = $clog2(WB_FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;

  // Writeback FIFO state
  logic [ADDR_WIDTH-1:0] fifo_addr [WB_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WB_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      level;
  logic [LVL_W-1:0]      level_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BANK_BITS-1:0]  head_bank;
  logic                  push;
  logic                  pop;

  // Read-port decode, arbitration and response pipeline
  logic [ADDR_WIDTH-1:0] rp_word [RD_PORTS];
  logic [BANK_BITS-1:0]  rp_bank [RD_PORTS];
  logic [RD_PORTS-1:0]   raw_hit;
  logic [RD_PORTS-1:0]   grant;
  logic                  wb_grant;
  logic [BANK_NUM-1:0]   bank_taken;
  logic [RD_PORTS-1:0]   rvalid_q;
  logic [BANK_BITS-1:0]  bank_q [RD_PORTS];
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign fifo_full  = (level == LVL_W'(WB_FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign head_bank  = head_addr[BANK_BITS-1:0];

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rp_word[i] = rp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rp_bank[i] = rp_word[i][BANK_BITS-1:0];
    end
  end

  // An entry is live when its distance from the read pointer is below the level.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    raw_hit = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      for (int j = 0; j < WB_FIFO_DEPTH; j++) begin
        if (({1'b0, PTR_W'(j) - rd_ptr} < level) && (fifo_addr[j] == rp_word[i]))
          raw_hit[i] = 1'b1;
      end
    end
  end

  // A hazard-stalled read does not claim its bank, so the pending write can drain.
  always_comb begin
    bank_taken = '0;
    grant      = '0;
    wb_grant   = 1'b0;
    if (fifo_full) begin
      bank_taken[head_bank] = 1'b1;
      wb_grant              = 1'b1;
    end
    for (int i = 0; i < RD_PORTS; i++) begin
      if (rp_valid[i] && !raw_hit[i] && !bank_taken[rp_bank[i]]) begin
        grant[i]                = 1'b1;
        bank_taken[rp_bank[i]]  = 1'b1;
      end
    end
    if (!fifo_full && !fifo_empty && !bank_taken[head_bank]) begin
      wb_grant              = 1'b1;
      bank_taken[head_bank] = 1'b1;
    end
    if (rst) begin
      grant    = '0;
      wb_grant = 1'b0;
    end
  end

  assign rp_ready = grant;
  assign pop      = wb_grant;
  assign push     = wp_valid && wp_ready && !rst;

  always_comb begin
    bram_en    = '0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (wb_grant && (head_bank == BANK_BITS'(b))) begin
        bram_en[b]                              = 1'b1;
        bram_we[b]                              = 1'b1;
        bram_addr[b*BANK_AW +: BANK_AW]         = head_addr[ADDR_WIDTH-1:BANK_BITS];
        bram_wdata[b*DATA_WIDTH +: DATA_WIDTH]  = head_data;
      end else begin
        for (int i = 0; i < RD_PORTS; i++) begin
          if (grant[i] && (rp_bank[i] == BANK_BITS'(b))) begin
            bram_en[b]                      = 1'b1;
            bram_addr[b*BANK_AW +: BANK_AW] = rp_word[i][ADDR_WIDTH-1:BANK_BITS];
          end
        end
      end
    end
  end

  assign level_next = level + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      wp_ready <= 1'b1;
      wb_idle  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_next;
      wp_ready <= (level_next < LVL_W'(WB_FIFO_DEPTH));
      wb_idle  <= (level_next == '0);
    end
  end

  // NOTE: FIFO storage has no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wp_addr;
      fifo_data[wr_ptr] <= wp_wdata;
    end
  end

  assign wb_level = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RD_PORTS; i++) bank_q[i] <= '0;
    end else begin
      rvalid_q <= grant;
      for (int i = 0; i < RD_PORTS; i++) bank_q[i] <= rp_bank[i];
      if (|(rp_valid & ~grant) && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rp_rvalid    = rst ? '0 : rvalid_q;
  assign conflict_cnt = rst ? '0 : cnt_q;

  always_comb begin
    rp_rdata = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (rp_rvalid[i])
        rp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = bram_rdata[int'(bank_q[i])*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fram_bank_arbiter.sv
// Bench for fram_bank_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based reference model and a flat-memory view of the BRAM banks.
module tb_fram_bank_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int NP = 2;
  localparam int D  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP-1:0]  rp_valid;
  logic [NP*AW-1:0] rp_addr;
  logic [NP-1:0]  rp_ready;
  logic [NP-1:0]  rp_rvalid;
  logic [NP*DW-1:0] rp_rdata;
  logic           wp_valid;
  logic [AW-1:0]  wp_addr;
  logic [DW-1:0]  wp_wdata;
  logic           wp_ready;
  logic [NB-1:0]  bram_en;
  logic [NB-1:0]  bram_we;
  logic [NB*10-1:0] bram_addr;
  logic [NB*DW-1:0] bram_wdata;
  logic [NB*DW-1:0] bram_rdata;
  logic [2:0]     wb_level;
  logic           wb_idle;
  logic [15:0]    conflict_cnt;

  fram_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .rp_valid(rp_valid), .rp_addr(rp_addr), .rp_ready(rp_ready),
    .rp_rvalid(rp_rvalid), .rp_rdata(rp_rdata),
    .wp_valid(wp_valid), .wp_addr(wp_addr), .wp_wdata(wp_wdata), .wp_ready(wp_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .wb_level(wb_level), .wb_idle(wb_idle), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment: four 1-cycle-latency BRAMs viewed as one word-addressed memory.
  logic [DW-1:0] bram_mem [4096];
  logic [DW-1:0] bram_q   [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bram_en[b]) begin
        if (bram_we[b]) bram_mem[{bram_addr[b*10 +: 10], 2'(b)}] <= bram_wdata[b*DW +: DW];
        else            bram_q[b] <= bram_mem[{bram_addr[b*10 +: 10], 2'(b)}];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) bram_rdata[b*DW +: DW] = bram_q[b];
  end

  // Reference model: pending writes as a queue, memory contents as seen by readers.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           wq[$];
  logic [DW-1:0] ref_mem [4096];
  logic [NP-1:0] m_rvalid;
  logic [DW-1:0] m_rdata [NP];
  logic [15:0]   m_cnt;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  function automatic void model_arb(output logic [NP-1:0] rdy, output logic pop,
                                    output logic [NB-1:0] en, output logic [NB-1:0] we);
    logic [NB-1:0] taken;
    logic [AW-1:0] a;
    logic          raw;
    rdy = '0; pop = 1'b0; en = '0; we = '0; taken = '0;
    if (rst) return;
    if (wq.size() == D) begin
      taken[wq[0].addr[1:0]] = 1'b1;
      pop = 1'b1;
    end
    for (int i = 0; i < NP; i++) begin
      a   = rp_addr[i*AW +: AW];
      raw = 1'b0;
      foreach (wq[k]) if (wq[k].addr == a) raw = 1'b1;
      if (rp_valid[i] && !raw && !taken[a[1:0]]) begin
        rdy[i] = 1'b1;
        taken[a[1:0]] = 1'b1;
        en[a[1:0]] = 1'b1;
      end
    end
    if (!pop && wq.size() != 0 && !taken[wq[0].addr[1:0]]) pop = 1'b1;
    if (pop) begin
      en[wq[0].addr[1:0]] = 1'b1;
      we[wq[0].addr[1:0]] = 1'b1;
    end
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    logic [NP-1:0] rdy;
    logic          pop;
    logic [NB-1:0] en;
    logic [NB-1:0] we;
    logic          do_push;
    @(posedge clk);
    if (rst) begin
      wq.delete();
      m_rvalid = '0;
      m_cnt    = '0;
    end else begin
      model_arb(rdy, pop, en, we);
      for (int i = 0; i < NP; i++) begin
        m_rvalid[i] = rdy[i];
        if (rdy[i]) m_rdata[i] = ref_mem[rp_addr[i*AW +: AW]];
      end
      if (((rp_valid & ~rdy) != '0) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      do_push = wp_valid && (wq.size() < D);
      if (pop) begin
        ref_mem[wq[0].addr] = wq[0].data;
        void'(wq.pop_front());
      end
      if (do_push) wq.push_back('{wp_addr, wp_wdata});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rp_valid = 2'b11; rp_addr = {12'h005, 12'h004}; wp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (rp_ready !== 2'b00) begin n_err++; $display("FAIL reset_rp_ready got %b exp 00", rp_ready); end
      n_vec++; if (bram_en !== 4'b0000) begin n_err++; $display("FAIL reset_bram_en got %b exp 0000", bram_en); end
      n_vec++; if (rp_rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got %b exp 00", rp_rvalid); end
      n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
      step();
    end
    rst = 1'b0; rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (wp_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_wp_ready got %b exp 1", wp_ready); end
    n_vec++; if (wb_level !== 3'd0) begin n_err++; $display("FAIL post_reset_level got %0d exp 0", wb_level); end
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL post_reset_idle got %b exp 1", wb_idle); end
    step();
  endtask

  task automatic test_parallel();
    rp_valid = 2'b11; rp_addr = {12'h005, 12'h004};
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b11) begin n_err++; $display("FAIL parallel_ready got %b exp 11", rp_ready); end
    n_vec++; if (bram_en !== 4'b0011 || bram_we !== 4'b0000) begin n_err++; $display("FAIL parallel_en got en=%b we=%b exp en=0011 we=0000", bram_en, bram_we); end
    step();
    rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (rp_rvalid !== 2'b11) begin n_err++; $display("FAIL parallel_rvalid got %b exp 11", rp_rvalid); end
    n_vec++; if (rp_rdata[31:0] !== pre(12'h004)) begin n_err++; $display("FAIL parallel_rdata0 got %h exp %h", rp_rdata[31:0], pre(12'h004)); end
    n_vec++; if (rp_rdata[63:32] !== pre(12'h005)) begin n_err++; $display("FAIL parallel_rdata1 got %h exp %h", rp_rdata[63:32], pre(12'h005)); end
    step();
  endtask

  task automatic test_conflict();
    rp_valid = 2'b11; rp_addr = {12'h00C, 12'h008};
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b01) begin n_err++; $display("FAIL conflict_ready_t got %b exp 01", rp_ready); end
    step();
    rp_valid = 2'b10;
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b10) begin n_err++; $display("FAIL conflict_ready_t1 got %b exp 10", rp_ready); end
    n_vec++; if (rp_rvalid !== 2'b01 || rp_rdata[31:0] !== pre(12'h008)) begin n_err++; $display("FAIL conflict_rd0 got v=%b d=%h exp v=01 d=%h", rp_rvalid, rp_rdata[31:0], pre(12'h008)); end
    step();
    rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (rp_rvalid !== 2'b10 || rp_rdata[63:32] !== pre(12'h00C)) begin n_err++; $display("FAIL conflict_rd1 got v=%b d=%h exp v=10 d=%h", rp_rvalid, rp_rdata[63:32], pre(12'h00C)); end
    n_vec++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL conflict_cnt got %0d exp 1", conflict_cnt); end
    step();
  endtask

  task automatic test_fifo_full();
    rp_valid = 2'b01; rp_addr = {12'h000, 12'h100};
    for (int k = 0; k < 4; k++) begin
      wp_valid = 1'b1; wp_addr = 12'h200 + 12'(4*k); wp_wdata = 32'hC0DE_0000 + k;
      @(negedge clk);
      n_vec++; if (rp_ready !== 2'b01) begin n_err++; $display("FAIL full_fill_ready[%0d] got %b exp 01", k, rp_ready); end
      step();
    end
    wp_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (wp_ready !== 1'b0 || wb_level !== 3'd4) begin n_err++; $display("FAIL full_state got rdy=%b lvl=%0d exp rdy=0 lvl=4", wp_ready, wb_level); end
    n_vec++; if (bram_we !== 4'b0001 || bram_en !== 4'b0001) begin n_err++; $display("FAIL full_head_write got en=%b we=%b exp 0001/0001", bram_en, bram_we); end
    n_vec++; if (rp_ready !== 2'b00) begin n_err++; $display("FAIL full_port_stall got %b exp 00", rp_ready); end
    step();
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b01 || bram_we !== 4'b0000) begin n_err++; $display("FAIL full_after got ready=%b we=%b exp 01/0000", rp_ready, bram_we); end
    n_vec++; if (wp_ready !== 1'b1 || wb_level !== 3'd3) begin n_err++; $display("FAIL full_after_level got rdy=%b lvl=%0d exp 1/3", wp_ready, wb_level); end
    n_vec++; if (rp_rvalid !== 2'b00) begin n_err++; $display("FAIL full_after_rvalid got %b exp 00", rp_rvalid); end
    n_vec++; if (conflict_cnt !== 16'd2) begin n_err++; $display("FAIL full_cnt got %0d exp 2", conflict_cnt); end
    step();
    rp_valid = 2'b00;
    repeat (3) begin @(negedge clk); step(); end
    @(negedge clk);
    n_vec++; if (wb_idle !== 1'b1 || wb_level !== 3'd0) begin n_err++; $display("FAIL full_drain got idle=%b lvl=%0d exp 1/0", wb_idle, wb_level); end
    step();
  endtask

  task automatic test_raw();
    wp_valid = 1'b1; wp_addr = 12'h020; wp_wdata = 32'h0000_1234; rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (bram_we !== 4'b0000) begin n_err++; $display("FAIL raw_no_bypass got we=%b exp 0000", bram_we); end
    step();
    wp_valid = 1'b0; rp_valid = 2'b10; rp_addr = {12'h020, 12'h000};
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b00) begin n_err++; $display("FAIL raw_stall got %b exp 00", rp_ready); end
    n_vec++; if (bram_we !== 4'b0001 || bram_addr[9:0] !== 10'h008 || bram_wdata[31:0] !== 32'h0000_1234) begin n_err++; $display("FAIL raw_write got we=%b a=%h d=%h exp 0001/008/00001234", bram_we, bram_addr[9:0], bram_wdata[31:0]); end
    step();
    @(negedge clk);
    n_vec++; if (rp_ready !== 2'b10) begin n_err++; $display("FAIL raw_grant got %b exp 10", rp_ready); end
    step();
    rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (rp_rvalid !== 2'b10 || rp_rdata[63:32] !== 32'h0000_1234) begin n_err++; $display("FAIL raw_data got v=%b d=%h exp 10/00001234", rp_rvalid, rp_rdata[63:32]); end
    n_vec++; if (conflict_cnt !== 16'd3) begin n_err++; $display("FAIL raw_cnt got %0d exp 3", conflict_cnt); end
    step();
  endtask

  task automatic test_reset_flush();
    rp_valid = 2'b01; rp_addr = {12'h000, 12'h100};
    for (int k = 0; k < 3; k++) begin
      wp_valid = 1'b1; wp_addr = 12'h300 + 12'(4*k); wp_wdata = 32'hDEAD_0000 + k;
      @(negedge clk); step();
    end
    wp_valid = 1'b0; rp_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    n_vec++; if (wb_level !== 3'd3) begin n_err++; $display("FAIL flush_pre_level got %0d exp 3", wb_level); end
    n_vec++; if (bram_we !== 4'b0000) begin n_err++; $display("FAIL flush_rst_we got %b exp 0000", bram_we); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (wb_level !== 3'd0 || wb_idle !== 1'b1 || wp_ready !== 1'b1) begin n_err++; $display("FAIL flush_level got lvl=%0d idle=%b rdy=%b exp 0/1/1", wb_level, wb_idle, wp_ready); end
    n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL flush_cnt got %0d exp 0", conflict_cnt); end
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      n_vec++; if (bram_we !== 4'b0000) begin n_err++; $display("FAIL flush_no_write[%0d] got %b exp 0000", k, bram_we); end
    end
    step();
    rp_valid = 2'b01; rp_addr = {12'h000, 12'h300};
    @(negedge clk); step();
    rp_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (rp_rvalid !== 2'b01 || rp_rdata[31:0] !== pre(12'h300)) begin n_err++; $display("FAIL flush_old_data got v=%b d=%h exp 01/%h", rp_rvalid, rp_rdata[31:0], pre(12'h300)); end
    step();
  endtask

  task automatic test_random(input int cycles);
    logic [NP-1:0] hold;
    logic [NP-1:0] rdy;
    logic          pop;
    logic [NB-1:0] en;
    logic [NB-1:0] we;
    logic [DW-1:0] exp_d;
    hold = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!hold[i]) begin
          rp_valid[i] = ($urandom % 3) != 0;
          rp_addr[i*AW +: AW] = 12'($urandom_range(0, 15));
        end
      end
      wp_valid = $urandom % 2;
      wp_addr  = 12'($urandom_range(0, 15));
      wp_wdata = $urandom;
      @(negedge clk);
      model_arb(rdy, pop, en, we);
      n_vec++; if (rp_ready !== rdy) begin n_err++; $display("FAIL rand_ready c%0d got %b exp %b", c, rp_ready, rdy); end
      n_vec++; if (bram_en !== en || bram_we !== we) begin n_err++; $display("FAIL rand_bram c%0d got en=%b we=%b exp en=%b we=%b", c, bram_en, bram_we, en, we); end
      n_vec++; if (rp_rvalid !== m_rvalid) begin n_err++; $display("FAIL rand_rvalid c%0d got %b exp %b", c, rp_rvalid, m_rvalid); end
      for (int i = 0; i < NP; i++) begin
        exp_d = m_rvalid[i] ? m_rdata[i] : '0;
        n_vec++; if (rp_rdata[i*DW +: DW] !== exp_d) begin n_err++; $display("FAIL rand_rdata%0d c%0d got %h exp %h", i, c, rp_rdata[i*DW +: DW], exp_d); end
      end
      n_vec++; if (wb_level !== 3'(wq.size()) || wp_ready !== (wq.size() < D)) begin n_err++; $display("FAIL rand_fifo c%0d got lvl=%0d rdy=%b exp lvl=%0d", c, wb_level, wp_ready, wq.size()); end
      n_vec++; if (conflict_cnt !== m_cnt) begin n_err++; $display("FAIL rand_cnt c%0d got %0d exp %0d", c, conflict_cnt, m_cnt); end
      hold = rp_valid & ~rdy;
      step();
    end
    rp_valid = '0; wp_valid = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      bram_mem[a] = pre(12'(a));
      ref_mem[a]  = pre(12'(a));
    end
    for (int b = 0; b < NB; b++) bram_q[b] = '0;
    m_rvalid = '0; m_cnt = '0;
    for (int i = 0; i < NP; i++) m_rdata[i] = '0;
    rst = 1'b1; rp_valid = '0; rp_addr = '0; wp_valid = 1'b0; wp_addr = '0; wp_wdata = '0;
    step();
    test_reset();
    test_parallel();
    test_conflict();
    test_fifo_full();
    test_raw();
    test_reset_flush();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
